flit_splitter: RTL and testbench
================================

Name: flit_splitter

Overview:
- Upstream neighbour of the NoC supplier stage. Takes one 32-bit payload word per valid/ready handshake and emits four 21-bit flits, one byte per flit.
- Each flit carries a chunk index in [11:8]. The downstream stage collects four flits, sorts them by index and repacks the bytes into a 32-bit word.
- Output side drives the downstream wr_en; out_ready is normally tied to the downstream !buf_full.

Parameters:
- DATA_SIZE, 32, payload word width. Fixed: 4 chunks of 8 bits.
- IN_SIZE, 21, flit width. Must equal 12 + DST_W + TAG_W.
- DST_W, 4, destination field width.
- TAG_W, 5, packet tag width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  payload word valid
- in_ready  output  1  block accepts the word this cycle
- in_data  input  DATA_SIZE  payload word
- in_dst  input  DST_W  destination, sampled with in_data
- out_valid  output  1  flit valid (downstream wr_en)
- out_ready  input  1  downstream can take a flit
- out_flit  output  IN_SIZE  flit {dst, tag, idx[3:0], byte[7:0]}
- busy  output  1  a word is held, not all flits sent
- word_count  output  16  words fully sent, wraps at 2^16

Behaviour:
- Reset clears all of the following:
  - state to IDLE
  - held word, held dst, flit counter cnt[1:0]
  - tag, word_count
  - outputs to 0: out_valid=0, out_flit=0, busy=0. in_ready=1 once reset deasserts.
- Reset mid-word: unsent flits are discarded and the tag returns to 0.
- States:
  - IDLE: out_valid=0, in_ready=1. On in_valid, latch in_data, in_dst and the current tag; set cnt=0; go to SEND.
  - SEND: out_valid=1, busy=1. On out_valid&&out_ready:
    - cnt<3: cnt increments.
    - cnt==3: word done. word_count increments and tag increments (wraps modulo 2^TAG_W).
      - If in_valid is also high: new word latched in the same cycle, stay in SEND, cnt=0, no bubble.
      - Otherwise: go to IDLE.
- in_ready: 1 in IDLE; in SEND only when cnt==3 && out_ready (single-cycle, combinational on out_ready).
- Latency: first flit valid one cycle after the input handshake. Sustained throughput is 1 word per 4 cycles.
- Flit field layout:
  - [20:17] held dst
  - [16:12] tag of the word
  - [11:8] chunk index k, with [11:10]=0 and [9:8]=k
  - [7:0] = word[8k+7:8k]
- Chunk index by default: k = cnt. Flit order is 0,1,2,3.
- out_flit and out_valid derive only from registers; out_flit holds stable while out_valid && !out_ready.
- in_data and in_dst are ignored unless in_valid&&in_ready.
- No word is ever split across two different tag values.

Optional Feature:
- FLIT_SCRAMBLE_EN
  - Defined: the chunk index becomes k = (cnt + tag[1:0]) mod 4, so flit order rotates per word. This exercises the downstream index sort. The data byte always matches its idx field.
  - Undefined: k = cnt, in-order emission.

Test Plan:
- Single word: in_data=0xDDCCBBAA, dst=3, out_ready=1 -> flits 0x600AA, 0x601BB, 0x602CC, 0x603DD on 4 consecutive cycles; then word_count=1, state IDLE.
- Back-to-back: second word 0x44332211, dst=1, offered during the last flit -> next cycle 0x21011, 0x21122, 0x21233, 0x21344; no bubble; in_ready high only on the cnt==3 cycle.
- Backpressure: out_ready=0 for 3 cycles at cnt==2 -> out_flit holds the idx-2 flit, out_valid stays 1, in_ready=0, no flit lost or duplicated.
- Tag wrap: 33 words -> tags 0..31 then 0; word_count=33.
- Reset mid-word: rst after 2 flits -> out_valid=0 and busy=0 immediately (async); the next word gets tag 0 and idx starts at 0.
- FLIT_SCRAMBLE_EN, word with tag=1, data 0x44332211 -> idx order 1,2,3,0 with bytes 0x22,0x33,0x44,0x11.

Source files
------------

// File: rtl/flit_splitter.sv
//==============================================================================
//  Module   : flit_splitter
//  Purpose  : Splits one 32-bit payload word per valid/ready handshake into
//             four 21-bit flits {dst, tag, idx[3:0], byte[7:0]}, one byte per
//             flit, for the downstream NoC supplier stage.
//  Options  : FLIT_SCRAMBLE_EN - rotate chunk order per word by tag[1:0]
//             (default build: in-order emission, idx = 0,1,2,3).
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module flit_splitter #(
  parameter int DATA_SIZE = 32,
  parameter int IN_SIZE   = 21,
  parameter int DST_W     = 4,
  parameter int TAG_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic [DST_W-1:0]     in_dst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IN_SIZE-1:0]   out_flit,
  output logic                 busy,
  output logic [15:0]          word_count
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_SEND = 1'b1;

  // Registered state and its next-state values
  logic [0:0]           state_q, state_d;
  logic [DATA_SIZE-1:0] word_q,  word_d;
  logic [DST_W-1:0]     dst_q,   dst_d;
  logic [TAG_W-1:0]     tag_q,   tag_d;
  logic [1:0]           cnt_q,   cnt_d;
  logic [15:0]          wcnt_q,  wcnt_d;

  // Handshake and flit-assembly helpers
  logic                 w_send;
  logic                 w_fire;
  logic                 w_last;
  logic                 w_accept;
  logic [1:0]           w_idx;
  logic [7:0]           w_byte;

  // The tag register is only updated on the final flit of a word, so the
  // word currently being emitted always sees one constant tag value.
  assign w_send   = (state_q == c_SEND);
  assign w_fire   = w_send & out_ready;
  assign w_last   = w_fire & (cnt_q == 2'd3);
  // A new word is taken when idle, or on the cycle the last flit leaves so
  // that back-to-back words stream without a bubble.
  assign in_ready = ~w_send | ((cnt_q == 2'd3) & out_ready);
  assign w_accept = in_valid & in_ready;

`ifdef FLIT_SCRAMBLE_EN
  // Rotate emission order per word so the downstream index sort is exercised
  assign w_idx = cnt_q + tag_q[1:0];
`else
  assign w_idx = cnt_q;
`endif

  // Pick the payload byte that matches the chunk index carried in the flit
  always_comb begin
    w_byte = word_q[7:0];
    case (w_idx)
      2'd0:    w_byte = word_q[7:0];
      2'd1:    w_byte = word_q[15:8];
      2'd2:    w_byte = word_q[23:16];
      default: w_byte = word_q[31:24];
    endcase
  end

  // Outputs depend only on registers; the flit is held while stalled
  assign out_valid  = w_send;
  assign busy       = w_send;
  assign word_count = wcnt_q;
  assign out_flit   = w_send ? {dst_q, tag_q, 2'b00, w_idx, w_byte}
                             : {IN_SIZE{1'b0}};

  // Next-state: advance the chunk counter, retire words, accept new words
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    dst_d   = dst_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;

    if (w_fire) begin
      cnt_d = cnt_q + 2'd1;
    end

    if (w_last) begin
      wcnt_d  = wcnt_q + 16'd1;
      tag_d   = tag_q + {{(TAG_W-1){1'b0}}, 1'b1};
      state_d = c_IDLE;
    end

    // Accepting overrides the retire-to-idle above for back-to-back words
    if (w_accept) begin
      word_d  = in_data;
      dst_d   = in_dst;
      cnt_d   = 2'd0;
      state_d = c_SEND;
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_IDLE;
      word_q  <= {DATA_SIZE{1'b0}};
      dst_q   <= {DST_W{1'b0}};
      tag_q   <= {TAG_W{1'b0}};
      cnt_q   <= 2'd0;
      wcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      dst_q   <= dst_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flit_splitter.sv
//==============================================================================
//  Module   : tb_flit_splitter
//  Purpose  : Directed self-checking bench for flit_splitter. Honours
//             FLIT_SCRAMBLE_EN when choosing expected flit order.
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_flit_splitter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_dst;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_flit;
  logic        busy;
  logic [15:0] word_count;

  int checks;
  int errors;

  logic [20:0] t2a [4];
  logic [20:0] t2b [4];
  logic [20:0] t3  [4];

  flit_splitter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dst     (in_dst),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_flit   (out_flit),
    .busy       (busy),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
`ifdef FLIT_SCRAMBLE_EN
    t2a[0] = 21'h21122; t2a[1] = 21'h21233; t2a[2] = 21'h21344; t2a[3] = 21'h21011;
    t2b[0] = 21'h42299; t2b[1] = 21'h42388; t2b[2] = 21'h420BB; t2b[3] = 21'h421AA;
    t3[0]  = 21'h1E33CA; t3[1] = 21'h1E300D; t3[2] = 21'h1E31F0; t3[3] = 21'h1E32FE;
`else
    t2a[0] = 21'h21011; t2a[1] = 21'h21122; t2a[2] = 21'h21233; t2a[3] = 21'h21344;
    t2b[0] = 21'h420BB; t2b[1] = 21'h421AA; t2b[2] = 21'h42299; t2b[3] = 21'h42388;
    t3[0]  = 21'h1E300D; t3[1] = 21'h1E31F0; t3[2] = 21'h1E32FE; t3[3] = 21'h1E33CA;
`endif

    // ---- reset state
    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_dst = 4'h0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_flit", 32'(out_flit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // ---- single word, tag 0
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_dst = 4'd3;
    #1;
    check("t1_accept_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_flit0", 32'(out_flit), 32'h600AA);
    check("t1_ready0", 32'(in_ready), 32'd0);
    @(negedge clk); #1;
    check("t1_flit1", 32'(out_flit), 32'h601BB);
    @(negedge clk); #1;
    check("t1_flit2", 32'(out_flit), 32'h602CC);
    @(negedge clk); #1;
    check("t1_flit3", 32'(out_flit), 32'h603DD);
    check("t1_ready3", 32'(in_ready), 32'd1);
    @(negedge clk); #1;
    check("t1_idle_valid", 32'(out_valid), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_word_count", 32'(word_count), 32'd1);

    // ---- back-to-back: tag 1 word then tag 2 word with no bubble
    in_valid = 1'b1; in_data = 32'h44332211; in_dst = 4'd1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t2a_flit0", 32'(out_flit), 32'(t2a[0]));
    check("t2a_ready0", 32'(in_ready), 32'd0);
    @(negedge clk); #1;
    check("t2a_flit1", 32'(out_flit), 32'(t2a[1]));
    check("t2a_ready1", 32'(in_ready), 32'd0);
    @(negedge clk); #1;
    check("t2a_flit2", 32'(out_flit), 32'(t2a[2]));
    check("t2a_ready2", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h8899AABB; in_dst = 4'd2;
    #1;
    check("t2a_flit3", 32'(out_flit), 32'(t2a[3]));
    check("t2a_ready3", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t2b_no_bubble", 32'(out_valid), 32'd1);
    check("t2b_flit0", 32'(out_flit), 32'(t2b[0]));
    check("t2b_word_count", 32'(word_count), 32'd2);
    check("t2b_ready0", 32'(in_ready), 32'd0);
    @(negedge clk); #1;
    check("t2b_flit1", 32'(out_flit), 32'(t2b[1]));
    @(negedge clk); #1;
    check("t2b_flit2", 32'(out_flit), 32'(t2b[2]));
    @(negedge clk); #1;
    check("t2b_flit3", 32'(out_flit), 32'(t2b[3]));

    // ---- backpressure at cnt==2 for three cycles, tag 3
    @(negedge clk); #1;
    check("t2_word_count", 32'(word_count), 32'd3);
    check("t2_idle_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_data = 32'hCAFEF00D; in_dst = 4'hF;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t3_flit0", 32'(out_flit), 32'(t3[0]));
    @(negedge clk); #1;
    check("t3_flit1", 32'(out_flit), 32'(t3[1]));
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("t3_stall1_flit", 32'(out_flit), 32'(t3[2]));
    check("t3_stall1_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_dst = 4'h9;
    #1;
    check("t3_stall2_flit", 32'(out_flit), 32'(t3[2]));
    check("t3_stall2_valid", 32'(out_valid), 32'd1);
    check("t3_stall2_ready", 32'(in_ready), 32'd0);
    @(negedge clk); #1;
    check("t3_stall3_flit", 32'(out_flit), 32'(t3[2]));
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    check("t3_release_flit", 32'(out_flit), 32'(t3[2]));
    @(negedge clk); #1;
    check("t3_flit3", 32'(out_flit), 32'(t3[3]));
    check("t3_ready3", 32'(in_ready), 32'd1);
    @(negedge clk); #1;
    check("t3_word_count", 32'(word_count), 32'd4);
    check("t3_idle_valid", 32'(out_valid), 32'd0);

    // ---- asynchronous reset after two flits of a tag-4 word
    in_valid = 1'b1; in_data = 32'h0F0E0D0C; in_dst = 4'd6;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_flit", 32'(out_flit), 32'd0);
    check("t5_rst_word_count", 32'(word_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 32'h55667788; in_dst = 4'd7;
    #1;
    check("t5_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t5_flit0", 32'(out_flit), 32'hE0088);
    check("t5_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("t5_flit3", 32'(out_flit), 32'hE0355);
    @(negedge clk); #1;
    check("t5_word_count", 32'(word_count), 32'd1);

    // ---- tag wrap: 33 back-to-back words from a clean reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 32'h0; in_dst = 4'h0;
    for (int w = 0; w < 33; w++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("wrap_tag", 32'(out_flit[16:12]), 32'(w % 32));
      repeat (2) @(negedge clk);
      @(negedge clk);
      if (w < 32) begin
        in_valid = 1'b1;
        in_data  = 32'(w + 1);
      end
    end
    @(negedge clk); #1;
    check("wrap_word_count", 32'(word_count), 32'd33);
    check("wrap_idle_valid", 32'(out_valid), 32'd0);
    check("wrap_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
